video_stream_packer: RTL and testbench

- Transmit end of the video AXI-Stream link.
- Accepts one 24-bit RGB pixel per handshake from the Mandelbrot pixel pipeline.
- Packs 4 pixels into 3 32-bit words, tracks line and frame position, and drives tdata/tkeep/tlast (EOL)/tuser (SOF) with full tready backpressure.
- Output is consumed by the VDMA/stream checker.

---
 rtl/video_stream_packer_if.sv | 39 +++
 rtl/video_stream_packer.sv | 139 +++++++++++++
 tb/tb_video_stream_packer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_stream_packer_if.sv
// Handshake bundle between the Mandelbrot pixel pipeline, the packer and the
// downstream AXI-Stream sink.
//   Pixel side : in_valid/in_ready handshake carrying in_r/in_g/in_b plus the
//                in_sof frame-start hint.
//   Stream side: out_stream_tdata/tkeep/tlast/tuser/tvalid with tready
//                backpressure from the sink.
// slave  : the packer's view (consumes pixels, produces stream words).
// master : the environment's view (produces pixels, consumes stream words).
interface video_stream_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_r;
    logic [7:0]  in_g;
    logic [7:0]  in_b;
    logic        in_sof;

    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;

    modport slave (
        input  in_valid, in_r, in_g, in_b, in_sof,
        output in_ready,
        output out_stream_tdata, out_stream_tkeep, out_stream_tlast,
        output out_stream_tuser, out_stream_tvalid,
        input  out_stream_tready
    );

    modport master (
        output in_valid, in_r, in_g, in_b, in_sof,
        input  in_ready,
        input  out_stream_tdata, out_stream_tkeep, out_stream_tlast,
        input  out_stream_tuser, out_stream_tvalid,
        output out_stream_tready
    );
endinterface

// File: rtl/video_stream_packer.sv
// Transmit end of the video AXI-Stream link. Packs 24-bit RGB pixels
// (P = {r, g, b}) four at a time into three little-endian 32-bit words,
// tracks word/line position to drive tlast (end of line) and tuser (start of
// frame), and honours full tready backpressure with a one-word output register.
// Ports:
//   clk          single clock
//   rst          asynchronous active-low reset
//   bus          video_stream_packer_if.slave: pixel handshake in, stream out
//   sync_err     one-cycle pulse when in_sof arrives away from a frame start
//   frame_count  completed frames, wraps at 2^16
module video_stream_packer #(
    parameter int X_PIXELS = 960,
    parameter int Y_SIZE   = 720
) (
    input  logic                        clk,
    input  logic                        rst,
    video_stream_packer_if.slave        bus,
    output logic                        sync_err,
    output logic [15:0]                 frame_count
);
    localparam int X_WORDS = X_PIXELS * 3 / 4;
    localparam int WC_W    = (X_WORDS > 1) ? $clog2(X_WORDS) : 1;
    localparam int LC_W    = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(X_WORDS - 1);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(Y_SIZE - 1);

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    phase_t          phase;
    logic [23:0]     residue;
    logic [WC_W-1:0] word_cnt;
    logic [LC_W-1:0] line_cnt;

    logic [31:0]     tdata_p1;
    logic            tlast_p1;
    logic            tuser_p1;
    logic            vld_p1;

    logic [23:0]     pix;
    logic            in_ready_c;
    logic            accept;
    logic            at_frame_start;
    logic            resync;
    logic            load;
    logic [31:0]     word_nxt;
    logic [23:0]     residue_nxt;

    assign pix = {bus.in_r, bus.in_g, bus.in_b};

    // PH0 never produces a word, so it can always take a pixel; the other
    // phases need a free (or draining) output register.
    assign in_ready_c     = (phase == PH0) || !vld_p1 || bus.out_stream_tready;
    assign accept         = bus.in_valid && in_ready_c;
    assign at_frame_start = (phase == PH0) && (word_cnt == '0) && (line_cnt == '0);
    assign resync         = accept && bus.in_sof && !at_frame_start;
    // A pixel carrying in_sof always restarts as P0, so it never completes a word.
    assign load           = accept && !bus.in_sof && (phase != PH0);

    // Byte stream is little-endian: the oldest pixel byte lands in tdata[7:0].
    always_comb begin
        word_nxt    = '0;
        residue_nxt = pix;
        case (phase)
            PH0: residue_nxt = pix;
            PH1: begin
                word_nxt    = {pix[7:0], residue};
                residue_nxt = {8'h00, pix[23:8]};
            end
            PH2: begin
                word_nxt    = {pix[15:0], residue[15:0]};
                residue_nxt = {16'h0000, pix[23:16]};
            end
            PH3: begin
                word_nxt    = {pix, residue[7:0]};
                residue_nxt = '0;
            end
            default: ;
        endcase
    end

    // ---- stage p1: phase FSM, position counters and output word register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase       <= PH0;
            residue     <= '0;
            word_cnt    <= '0;
            line_cnt    <= '0;
            frame_count <= '0;
            sync_err    <= 1'b0;
            tdata_p1    <= '0;
            tlast_p1    <= 1'b0;
            tuser_p1    <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            sync_err <= resync;

            if (accept) begin
                if (bus.in_sof) begin
                    // Restart the frame from this pixel; a word already held in
                    // the output register is left untouched and still delivered.
                    phase    <= PH1;
                    residue  <= pix;
                    word_cnt <= '0;
                    line_cnt <= '0;
                end else begin
                    phase   <= phase_t'(phase + 2'd1);
                    residue <= residue_nxt;
                end
            end

            if (load) begin
                tdata_p1 <= word_nxt;
                tuser_p1 <= (word_cnt == '0) && (line_cnt == '0);
                tlast_p1 <= (word_cnt == WC_LAST);
                vld_p1   <= 1'b1;
                if (word_cnt == WC_LAST) begin
                    word_cnt <= '0;
                    if (line_cnt == LC_LAST) begin
                        line_cnt    <= '0;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        line_cnt <= line_cnt + 1'b1;
                    end
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end else if (bus.out_stream_tready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.in_ready          = in_ready_c;
    assign bus.out_stream_tdata  = tdata_p1;
    assign bus.out_stream_tkeep  = 4'hF;
    assign bus.out_stream_tlast  = tlast_p1;
    assign bus.out_stream_tuser  = tuser_p1;
    assign bus.out_stream_tvalid = vld_p1;
endmodule

// File: tb/tb_video_stream_packer.sv
// Bench for video_stream_packer on a reduced 16x4 frame.
module tb_video_stream_packer;
    localparam int XP = 16;
    localparam int YS = 4;
    localparam int XW = XP * 3 / 4;
    localparam int FW = XW * YS;
    localparam int FP = XP * YS;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sync_err;
    logic [15:0] frame_count;

    video_stream_packer_if bus();

    video_stream_packer #(.X_PIXELS(XP), .Y_SIZE(YS)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sync_err   (sync_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        u;
        logic        l;
    } wd_t;

    typedef struct {
        logic [23:0] px;
        logic        has_w;
        logic [31:0] w;
        logic        u;
        logic        l;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;
    wd_t  exp_q[$];
    wd_t  got_q[$];
    logic [7:0] bq[$];
    int   pix_idx = 0;
    int   wfr = 0;
    int   frames = 0;
    logic sync_exp = 1'b0;
    logic held_v = 1'b0;
    logic [31:0] held_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: pixels become a byte stream; every 4 bytes form a word.
    // Frame position is counted in pixels and words of the whole frame.
    task automatic model_px(input logic [23:0] p, input logic sof);
        wd_t w;
        if (sof && pix_idx != 0) begin
            sync_exp = 1'b1;
            bq.delete();
            pix_idx = 0;
            wfr = 0;
        end
        bq.push_back(p[7:0]);
        bq.push_back(p[15:8]);
        bq.push_back(p[23:16]);
        if (bq.size() >= 4) begin
            w.d = {bq[3], bq[2], bq[1], bq[0]};
            w.u = (wfr == 0);
            w.l = ((wfr % XW) == XW - 1);
            exp_q.push_back(w);
            repeat (4) void'(bq.pop_front());
            wfr++;
            if (wfr == FW) begin
                wfr = 0;
                frames++;
            end
        end
        pix_idx++;
        if (pix_idx == FP) pix_idx = 0;
    endtask

    initial begin
        bus.out_stream_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_stream_tready = 1'b1;
                1:       bus.out_stream_tready = 1'($urandom % 2);
                default: bus.out_stream_tready = 1'b0;
            endcase
        end
    end

    // Monitor: sampled on the falling edge, between active edges.
    initial begin
        wd_t g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                bq.delete();
                pix_idx = 0;
                wfr = 0;
                frames = 0;
                sync_exp = 1'b0;
                held_v = 1'b0;
            end else begin
                chk("tvalid", bus.out_stream_tvalid, exp_q.size() != 0);
                chk("in_ready", bus.in_ready,
                    (pix_idx % 4 == 0) || (exp_q.size() == 0) || bus.out_stream_tready);
                chk("sync_err", sync_err, sync_exp);
                chk("frame_count", frame_count, 16'(frames));
                if (held_v) chk("stall_tdata", bus.out_stream_tdata, held_d);
                if (bus.out_stream_tvalid && exp_q.size() != 0) begin
                    chk("tdata", bus.out_stream_tdata, exp_q[0].d);
                    chk("tuser", bus.out_stream_tuser, exp_q[0].u);
                    chk("tlast", bus.out_stream_tlast, exp_q[0].l);
                    chk("tkeep", bus.out_stream_tkeep, 4'hF);
                end
                if (bus.out_stream_tvalid && bus.out_stream_tready) begin
                    g.d = bus.out_stream_tdata;
                    g.u = bus.out_stream_tuser;
                    g.l = bus.out_stream_tlast;
                    got_q.push_back(g);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                held_v = bus.out_stream_tvalid && !bus.out_stream_tready;
                held_d = bus.out_stream_tdata;
                sync_exp = 1'b0;
                if (bus.in_valid && bus.in_ready)
                    model_px({bus.in_r, bus.in_g, bus.in_b}, bus.in_sof);
            end
        end
    end

    task automatic send_px(input logic [23:0] p, input logic sof);
        int   t;
        logic acc;
        t = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_r = p[23:16];
        bus.in_g = p[15:8];
        bus.in_b = p[7:0];
        bus.in_sof = sof;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        chk("pixel_accepted", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        rdy_mode = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_done", exp_q.size(), 0);
        idle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[4];
        int          base;
        logic [23:0] px[53];

        vecs[0] = '{24'h112233, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[1] = '{24'h445566, 1'b1, 32'h66112233, 1'b1, 1'b0};
        vecs[2] = '{24'h778899, 1'b1, 32'h88994455, 1'b0, 1'b0};
        vecs[3] = '{24'hAABBCC, 1'b1, 32'hAABBCC77, 1'b0, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_r = '0;
        bus.in_g = '0;
        bus.in_b = '0;
        bus.in_sof = 1'b0;

        // Reset values
        #2;
        chk("rst_tvalid", bus.out_stream_tvalid, 1'b0);
        chk("rst_tdata", bus.out_stream_tdata, 32'h0);
        chk("rst_tuser", bus.out_stream_tuser, 1'b0);
        chk("rst_tlast", bus.out_stream_tlast, 1'b0);
        chk("rst_sync_err", sync_err, 1'b0);
        chk("rst_frame_count", frame_count, 16'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", bus.in_ready, 1'b1);

        // Four-pixel packing table, tready held high
        base = got_q.size();
        for (int i = 0; i < 4; i++) begin
            send_px(vecs[i].px, 1'b0);
            chk("tbl_tvalid", bus.out_stream_tvalid, vecs[i].has_w);
            if (vecs[i].has_w) begin
                chk("tbl_tdata", bus.out_stream_tdata, vecs[i].w);
                chk("tbl_tuser", bus.out_stream_tuser, vecs[i].u);
                chk("tbl_tlast", bus.out_stream_tlast, vecs[i].l);
            end
        end

        // Rest of the first frame at full rate
        for (int i = 4; i < FP; i++) send_px(24'($urandom), 1'b0);
        drain();
        chk("frame1_words", got_q.size() - base, FW);
        for (int i = 0; i < FW; i++) begin
            chk("frame1_tlast_pos", got_q[base + i].l, (i % XW) == XW - 1);
            chk("frame1_tuser_pos", got_q[base + i].u, i == 0);
        end
        chk("frame1_count", frame_count, 16'd1);

        // Two frames with random gaps and random tready; in_sof at true frame starts
        rdy_mode = 1;
        base = got_q.size();
        for (int i = 0; i < 2 * FP; i++) begin
            idle($urandom_range(0, 2));
            send_px(24'($urandom), 1'(i == 0 || i == FP));
        end
        drain();
        chk("rand_words", got_q.size() - base, 2 * FW);
        chk("rand_frame_count", frame_count, 16'd3);

        // in_sof on line 3 pixel 4 while the previous word is stalled
        base = got_q.size();
        for (int i = 0; i < 52; i++) begin
            px[i] = 24'($urandom);
            send_px(px[i], 1'b0);
        end
        rdy_mode = 2;
        px[52] = 24'($urandom);
        send_px(px[52], 1'b1);
        chk("sof_sync_err_pulse", sync_err, 1'b1);
        chk("sof_held_tvalid", bus.out_stream_tvalid, 1'b1);
        chk("sof_held_tdata", bus.out_stream_tdata, {px[51], px[50][23:16]});
        idle(1);
        chk("sof_sync_err_low", sync_err, 1'b0);
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) send_px(24'($urandom), 1'b0);
        drain();
        // 52 pixels -> 39 words, then 4 pixels of the new frame -> 3 words
        chk("sof_words", got_q.size() - base, 42);
        chk("sof_prior_word", got_q[base + 38].d, {px[51], px[50][23:16]});
        chk("sof_new_word_px", got_q[base + 39].d[23:0], px[52]);
        chk("sof_new_word_tuser", got_q[base + 39].u, 1'b1);
        chk("sof_frame_count", frame_count, 16'd3);

        // Async reset while a word is stalled
        rdy_mode = 2;
        send_px(24'($urandom), 1'b0);
        send_px(24'($urandom), 1'b0);
        chk("pre_reset_tvalid", bus.out_stream_tvalid, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_rst_tvalid", bus.out_stream_tvalid, 1'b0);
        chk("async_rst_tdata", bus.out_stream_tdata, 32'h0);
        chk("async_rst_tuser", bus.out_stream_tuser, 1'b0);
        chk("async_rst_frame_count", frame_count, 16'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        rdy_mode = 0;
        base = got_q.size();
        for (int i = 0; i < 4; i++) send_px(24'($urandom), 1'b0);
        drain();
        chk("post_rst_words", got_q.size() - base, 3);
        chk("post_rst_tuser_first", got_q[base].u, 1'b1);
        chk("post_rst_tuser_second", got_q[base + 1].u, 1'b0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
